// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed 7-segment display scan driver
//
// Purpose: drives NUM_DIGITS time-multiplexed common-anode 7-segment digits
// from a shadow register of 4-bit codes. Each digit is held for REFRESH_DIV
// clk cycles; the first cycle of every dwell is an all-off ghost guard.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst_n      - synchronous active-low reset
//   load       - capture strobe for digits_in / dp_in into the shadow register
//   digits_in  - 4-bit code per position, bits [3:0] are position 0 (LSD)
//   dp_in      - decimal point request per position, 1 = lit
//   blank_lz   - 1 = leading-zero blanking enabled
//   enable     - 1 = scan running, 0 = display dark (scan state held)
//   cathode    - segments {g,f,e,d,c,b,a}, active-low, registered
//   dp         - decimal point segment, active-low, registered
//   anode      - digit select, active-low, at most one bit low, registered
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic                    enable,
  output logic [6:0]              cathode,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode
);

  // A single-digit display still needs a 1-bit index register.
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   dpin_q, dpin_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]              cathode_q, cathode_d;
  logic                    dp_q, dp_d;

  logic       tick;
  logic [3:0] cur_code;
  logic       cur_dp;
  logic       cur_lz;
  logic       lz_run;
  logic [6:0] cur_seg;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hF:    s = 7'b0111111;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    tick     = enable && (presc_q == PRESC_LAST);
    cur_code = 4'd0;
    cur_dp   = 1'b0;
    cur_lz   = 1'b0;
    lz_run   = 1'b1;
    // Walk from the most significant position down: lz_run stays set only
    // while every code seen so far (this one included) is zero.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_run = lz_run && (digits_q[4*i +: 4] == 4'd0);
      if (idx_q == IW'(i)) begin
        cur_code = digits_q[4*i +: 4];
        cur_dp   = dpin_q[i];
        cur_lz   = lz_run && (i != 0);
      end
    end
    cur_seg = (blank_lz && cur_lz) ? 7'b1111111 : seg_decode(cur_code);
  end

  always_comb begin
    digits_d  = load ? digits_in : digits_q;
    dpin_d    = load ? dp_in : dpin_q;
    presc_d   = presc_q;
    idx_d     = idx_q;
    anode_d   = '1;
    cathode_d = 7'b1111111;
    dp_d      = 1'b1;
    if (enable) begin
      if (tick) begin
        presc_d = '0;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end else begin
        presc_d = presc_q + PW'(1);
      end
      cathode_d = cur_seg;
      dp_d      = ~cur_dp;
      // The cycle after a tick keeps every anode off while the index settles.
      if (!tick) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          anode_d[i] = !(idx_q == IW'(i));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digits_q  <= '0;
      dpin_q    <= '0;
      presc_q   <= '0;
      idx_q     <= '0;
      anode_q   <= '1;
      cathode_q <= 7'b1111111;
      dp_q      <= 1'b1;
    end else begin
      digits_q  <= digits_d;
      dpin_q    <= dpin_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
      dp_q      <= dp_d;
    end
  end

  assign anode   = anode_q;
  assign cathode = cathode_q;
  assign dp      = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  localparam int ND  = 4;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic        enable;
  logic [6:0]  cathode;
  logic        dp;
  logic [3:0]  anode;

  int tests = 0;
  int fails = 0;

  seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in),
    .dp_in(dp_in), .blank_lz(blank_lz), .enable(enable),
    .cathode(cathode), .dp(dp), .anode(anode)
  );

  always #5 clk = ~clk;

  // Reference model: integer dwell counter and digit index, shadow as array.
  int         m_presc;
  int         m_idx;
  logic [3:0] m_code [ND];
  logic [3:0] m_dpv;
  logic [3:0] e_anode;
  logic [6:0] e_cath;
  logic       e_dp;
  logic       e_chk;

  function automatic logic [6:0] seg_ref(input logic [3:0] c);
    case (c)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hF: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic model_edge();
    logic tk;
    logic blanked;
    if (!rst_n) begin
      m_presc = 0;
      m_idx   = 0;
      for (int j = 0; j < ND; j++) m_code[j] = 4'd0;
      m_dpv   = 4'd0;
      e_anode = 4'hF; e_cath = 7'h7F; e_dp = 1'b1; e_chk = 1'b1;
    end else begin
      tk = enable && (m_presc == DIV - 1);
      if (!enable) begin
        e_anode = 4'hF; e_cath = 7'h7F; e_dp = 1'b1; e_chk = 1'b1;
      end else begin
        blanked = blank_lz && (m_idx > 0);
        for (int j = m_idx; j < ND; j++) if (m_code[j] != 4'd0) blanked = 1'b0;
        e_cath = blanked ? 7'h7F : seg_ref(m_code[m_idx]);
        e_dp   = !m_dpv[m_idx];
        if (tk) begin
          e_anode = 4'hF; e_chk = 1'b0;
          m_presc = 0;
          m_idx   = (m_idx + 1) % ND;
        end else begin
          e_anode = 4'hF & ~(4'b0001 << m_idx); e_chk = 1'b1;
          m_presc = m_presc + 1;
        end
      end
      if (load) begin
        for (int j = 0; j < ND; j++) m_code[j] = digits_in[4*j +: 4];
        m_dpv = dp_in;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model_anode", {12'd0, anode}, {12'd0, e_anode});
    if (e_chk) begin
      chk("model_cathode", {9'd0, cathode}, {9'd0, e_cath});
      chk("model_dp", {15'd0, dp}, {15'd0, e_dp});
    end
  endtask

  // Waits for the first active cycle of the dwell that selects position pos.
  task automatic wait_sel(input int pos);
    logic [3:0] tgt;
    logic       was_guard;
    tgt = 4'hF & ~(4'b0001 << pos);
    was_guard = (anode === 4'hF);
    for (int n = 0; n < 40; n++) begin
      step();
      if (was_guard && anode === tgt) break;
      was_guard = (anode === 4'hF);
    end
    chk("sel_pos", {12'd0, anode}, {12'd0, tgt});
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    digits_in = d; dp_in = p; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; load = 1'b0; digits_in = 16'h0; dp_in = 4'h0;
    blank_lz = 1'b0; enable = 1'b1;
    @(negedge clk);
    step(); step();
    chk("rst_anode", {12'd0, anode}, 16'h000F);
    chk("rst_cathode", {9'd0, cathode}, 16'h007F);
    chk("rst_dp", {15'd0, dp}, 16'h0001);

    // First edge after reset release selects position 0 showing code 0.
    rst_n = 1'b1;
    step();
    chk("first_sel_anode", {12'd0, anode}, 16'h000E);
    chk("first_sel_cathode", {9'd0, cathode}, 16'h0040);

    // Basic scan of 1234.
    do_load(16'h1234, 4'h0);
    wait_sel(1); chk("scan_p1", {9'd0, cathode}, 16'h0030);
    wait_sel(2); chk("scan_p2", {9'd0, cathode}, 16'h0024);
    wait_sel(3); chk("scan_p3", {9'd0, cathode}, 16'h0079);
    wait_sel(0); chk("scan_p0", {9'd0, cathode}, 16'h0019);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (anode !== 4'hE) break;
      cnt++;
    end
    chk("dwell_extra_cycles", cnt[15:0], 16'd2);
    chk("guard_after_dwell", {12'd0, anode}, 16'h000F);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    do_load(16'h0070, 4'h0);
    wait_sel(3); chk("lz_p3", {9'd0, cathode}, 16'h007F);
    wait_sel(2); chk("lz_p2", {9'd0, cathode}, 16'h007F);
    wait_sel(1); chk("lz_p1", {9'd0, cathode}, 16'h0078);
    wait_sel(0); chk("lz_p0", {9'd0, cathode}, 16'h0040);
    do_load(16'h0000, 4'h0);
    wait_sel(1); chk("zero_p1", {9'd0, cathode}, 16'h007F);
    wait_sel(0); chk("zero_p0", {9'd0, cathode}, 16'h0040);

    // Minus sign, blank code, decimal point.
    do_load(16'hF00C, 4'b0010);
    wait_sel(3); chk("minus_p3", {9'd0, cathode}, 16'h003F);
    chk("dp_off_p3", {15'd0, dp}, 16'h0001);
    wait_sel(0); chk("blankcode_p0", {9'd0, cathode}, 16'h007F);
    chk("dp_off_p0", {15'd0, dp}, 16'h0001);
    wait_sel(1); chk("dp_on_p1", {15'd0, dp}, 16'h0000);

    // Disable mid-dwell at position 2, then resume the remaining dwell.
    blank_lz = 1'b0;
    do_load(16'h1234, 4'h0);
    wait_sel(2);
    step();
    enable = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("dis_anode", {12'd0, anode}, 16'h000F);
    chk("dis_cathode", {9'd0, cathode}, 16'h007F);
    chk("dis_dp", {15'd0, dp}, 16'h0001);
    enable = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (anode !== 4'hB) break;
      cnt++;
    end
    chk("resume_remaining_dwell", cnt[15:0], 16'd1);

    // Reset mid-scan with a coincident load.
    step();
    rst_n = 1'b0; digits_in = 16'hFFFF; dp_in = 4'hF; load = 1'b1;
    step();
    rst_n = 1'b1; load = 1'b0;
    chk("midrst_anode", {12'd0, anode}, 16'h000F);
    step();
    chk("midrst_p0_anode", {12'd0, anode}, 16'h000E);
    chk("midrst_p0_cathode", {9'd0, cathode}, 16'h0040);
    wait_sel(1); chk("midrst_shadow_p1", {9'd0, cathode}, 16'h0040);
    chk("midrst_dp_p1", {15'd0, dp}, 16'h0001);

    // Load coincident with the tick into position 1.
    do_load(16'h0090, 4'h0);
    wait_sel(0);
    step(); step();
    digits_in = 16'h0050; load = 1'b1;
    step();
    load = 1'b0;
    chk("tickload_guard", {12'd0, anode}, 16'h000F);
    step();
    chk("tickload_anode", {12'd0, anode}, 16'h000D);
    chk("tickload_cathode", {9'd0, cathode}, 16'h0012);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      load      = ($urandom_range(0, 5) == 0);
      digits_in = $urandom() & {{4{$urandom_range(0, 1) == 1}}, {4{$urandom_range(0, 1) == 1}},
                                {4{$urandom_range(0, 1) == 1}}, {4{1'b1}}};
      dp_in     = 4'($urandom());
      if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
      enable    = ($urandom_range(0, 7) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, SHALL set the number of multiplexed digit positions (legal range 1-8).
REQ-002 Parameter REFRESH_DIV, default 100000, SHALL set the number of clk cycles per digit dwell (legal value >= 2).
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port load, input, 1: capture strobe for digits_in/dp_in.
REQ-006 Port digits_in, input, 4*NUM_DIGITS: one 4-bit code per position; bits [3:0] are position 0, the least significant digit.
REQ-007 Port dp_in, input, NUM_DIGITS: decimal point request per position, 1 = lit.
REQ-008 Port blank_lz, input, 1: 1 = leading-zero blanking enabled.
REQ-009 Port enable, input, 1: 1 = scan running; 0 = display dark.
REQ-010 Port cathode, output, 7: segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-011 Port dp, output, 1: decimal point segment, active-low, registered.
REQ-012 Port anode, output, NUM_DIGITS: digit select, active-low, at most one bit low, registered.

Function
REQ-013 On a clk edge with load=1, digits_in and dp_in SHALL be copied into a shadow register; the display SHALL use only the shadow register.
REQ-014 The code map SHALL be: 0-9 standard digits (0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000); 4'hF = minus (0111111); 4'hA-4'hE = blank (1111111).
REQ-015 A prescaler SHALL count 0 to REFRESH_DIV-1 while enable=1 and wrap to 0; its terminal count is the tick.
REQ-016 On each tick, the scan index SHALL advance by 1 and wrap from NUM_DIGITS-1 to 0.
REQ-017 In the clk cycle after a tick, anode SHALL be all-ones (ghost guard); from the next cycle, the anode bit for the new scan index SHALL be 0.
REQ-018 cathode/dp SHALL present the shadow code/dp bit of the current scan index, with 1 cycle latency from the index or shadow change.
REQ-019 With blank_lz=1, the shadow code at a position SHALL be blanked (cathode = 1111111) if that code and every more-significant code are 0. Position 0 SHALL never be blanked. dp SHALL still follow dp_in for a blanked position.
REQ-020 With enable=0, anode SHALL be all-ones, cathode = 1111111, and dp = 1 from the next edge. The prescaler and scan index SHALL hold. Load SHALL remain functional.
REQ-021 When enable returns to 1, scanning SHALL resume from the held scan index and prescaler value.
REQ-022 If load and a tick occur on the same edge, the new digit SHALL display the newly loaded shadow value.

Reset
REQ-023 With rst_n=0 at a clk edge, the shadow register, prescaler, and scan index SHALL all clear to 0. Outputs SHALL become anode = all-ones, cathode = 1111111, and dp = 1.
REQ-024 Reset SHALL override load and enable on the same edge.
REQ-025 After rst_n rises with enable=1, position 0 SHALL be selected on the first edge and display code 0 (1000000).
REQ-026 Reset asserted mid-dwell or mid-guard SHALL abort the scan immediately with no partial state retained.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-027 Stimulus: load digits_in=16'h1234, then run 20 cycles. Required: anode sequence 1110, 1101, 1011, 0111 with cathodes 4, 3, 2, 1; each dwell is 3 cycles plus a 1-cycle all-ones guard.
REQ-028 Stimulus: blank_lz=1, load 16'h0070. Required: positions 3 and 2 show 1111111; position 1 shows 1111000; position 0 shows 1000000. Stimulus: load 16'h0000. Required: only position 0 lit, showing 1000000.
REQ-029 Stimulus: load 16'hF00C, dp_in=4'b0010. Required: position 3 shows 0111111; position 0 shows 1111111; dp=0 only while position 1 is selected.
REQ-030 Stimulus: enable=0 for 10 cycles mid-dwell at position 2. Required: all dark and prescaler frozen; after re-enable, position 2 completes its remaining dwell.
REQ-031 Stimulus: rst_n=0 for 1 cycle mid-scan with load=1 on the same edge. Required: shadow=0, anode=1111; after release, position 0 shows 1000000.
REQ-032 Stimulus: load coincident with a tick into position 1. Required: the first displayed cathode at position 1 equals the new code.
